csr_file: RTL and testbench
===========================

# csr_file

Machine-mode CSR register file for the npc core: decodes 12-bit CSR addresses, holds mstatus, mie, mtvec, mepc, mcause, mip and a CSR-mapped machine timer (mtime/mtimecmp), and executes CSRRW/CSRRS/CSRRC, trap entry and mret updates. It sits beside the execute stage; reads are combinational, and all state changes commit on the clock edge. It supersedes the plain address-to-index decoder with real storage, trap sequencing and a timer interrupt source.

## Interface
- XLEN, 64, register and data width
- MTIME_DIV, 1, core clocks per mtime increment (>=1)
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- csr_addr  in  12  CSR address
- csr_op  in  2  00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits)
- csr_wdata  in  XLEN  rs1/zimm operand
- csr_rdata  out  XLEN  current value of addressed CSR (0 if unmapped)
- csr_illegal  out  1  csr_op!=0 and address unmapped
- trap_valid  in  1  take trap this cycle
- trap_pc  in  XLEN  PC of trapping instruction
- trap_cause  in  XLEN  mcause value
- mret_valid  in  1  mret retires this cycle
- mtvec_out  out  XLEN  current mtvec
- mepc_out  out  XLEN  current mepc
- irq_timer  out  1  mstatus.MIE & mie.MTIE & mip.MTIP

## Operation
- Map: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x344 mip, 0x7C0 mtimecmp, 0x7C1 mtime; all others unmapped.
- New value: RW -> wdata; RS -> old | wdata; RC -> old & ~wdata. Written at the edge when csr_op!=0 and address mapped.
- Unmapped with op!=0: csr_illegal=1, csr_rdata=0, no state change. op==0: csr_illegal=0, no write, rdata still valid.
- Write masks: mtvec[1:0] and mepc[0] forced 0 (direct mode only); mip fully read-only (writes ignored, not illegal); mstatus writable bits only MIE[3], MPIE[7], MPP[12:11]; MPP reads 2'b11 always.
- mip.MTIP[7] = (mtime >= mtimecmp), unsigned, from registered values; other mip bits 0.
- Trap entry: mepc<=trap_pc & ~1, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
- mret: MIE<=MPIE, MPIE<=1.
- Priority same cycle: trap_valid > mret_valid > CSR write. Lower-priority action is dropped entirely (including a CSR write to an unrelated register); csr_illegal still reported combinationally.
- Timer: prescaler counts 0..MTIME_DIV-1; at terminal count mtime increments and prescaler wraps to 0. mtime wraps 2^XLEN-1 -> 0. CSR write to mtime overrides that cycle's increment and clears the prescaler. MTIME_DIV=1 means increment every cycle.

## Timing
- Reset (async, immediate): mstatus=0x1800, mie=0, mtvec=0, mepc=0, mcause=0, mtime=0, prescaler=0, mtimecmp=all ones; hence irq_timer=0, csr_rdata per address decode of reset state.
- Read: combinational, zero latency; reflects pre-edge state (read-before-write for CSRRW).
- Write/trap/mret: visible on outputs the cycle after the edge.
- irq_timer: combinational from registers; rises the cycle after the edge where mtime reaches mtimecmp, or after mtimecmp/mie/mstatus is written to enable it; falls the cycle after a trap clears MIE.
- Reset deassertion mid-operation: first edge after rst_n rises is a normal operating edge.

## Test plan
- Reset, read each mapped CSR -> mstatus=0x1800, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, others 0; addr 0x123 op=RW -> csr_illegal=1, rdata=0, no writes.
- RW mtvec=0x8000_0003 -> rdata old 0, next read 0x8000_0000; RS mie 0x80 then RC mie 0x80 -> 0x80 then 0.
- Set MIE=1, trap_valid with trap_pc=0x8000_0105, cause=0xB -> mepc=0x8000_0104, mcause=0xB, mstatus MIE=0 MPIE=1; mret -> MIE=1 MPIE=1.
- Same-cycle trap_valid, mret_valid and RW mtvec=0x40 -> only trap applied, mtvec unchanged.
- MTIME_DIV=4, mtimecmp=3, MIE=1, MTIE=1 -> mtime increments every 4 cycles, irq_timer rises the cycle after mtime becomes 3; RW mtime=0 -> irq_timer drops next cycle, prescaler restarts.
- Write mtime=all ones, MTIME_DIV=1 -> next cycle mtime=0; assert rst_n low mid-count -> all registers return to reset values immediately.

Source files
------------

// File: rtl/csr_file.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mepc/mcause/mip plus a CSR-mapped mtime/mtimecmp
// timer. Combinational reads, clocked CSRRW/RS/RC, trap entry and mret.
module csr_file #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned MTIME_DIV = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic            mret_valid,
    output logic [XLEN-1:0] mtvec_out,
    output logic [XLEN-1:0] mepc_out,
    output logic            irq_timer
);

    localparam logic [11:0] AddrMstatus  = 12'h300;
    localparam logic [11:0] AddrMie      = 12'h304;
    localparam logic [11:0] AddrMtvec    = 12'h305;
    localparam logic [11:0] AddrMepc     = 12'h341;
    localparam logic [11:0] AddrMcause   = 12'h342;
    localparam logic [11:0] AddrMip      = 12'h344;
    localparam logic [11:0] AddrMtimecmp = 12'h7C0;
    localparam logic [11:0] AddrMtime    = 12'h7C1;

    localparam int unsigned PW = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
    localparam logic [PW-1:0] PresTerm = PW'(MTIME_DIV - 1);

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [XLEN-1:0] mie_q, mie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtime_q, mtime_d;
    logic [XLEN-1:0] mtimecmp_q, mtimecmp_d;
    logic [PW-1:0]   presc_q, presc_d;

    logic [XLEN-1:0] mstatus_rd, mip_rd, old_val, new_val;
    logic            mapped, mtip, csr_we;

    // MPP is hard-wired to M-mode, so only MIE/MPIE need storage.
    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mstatus_mpie_q;
        mstatus_rd[3]     = mstatus_mie_q;
    end

    assign mtip = (mtime_q >= mtimecmp_q);

    always_comb begin
        mip_rd    = '0;
        mip_rd[7] = mtip;
    end

    always_comb begin
        mapped  = 1'b1;
        old_val = '0;
        case (csr_addr)
            AddrMstatus:  old_val = mstatus_rd;
            AddrMie:      old_val = mie_q;
            AddrMtvec:    old_val = mtvec_q;
            AddrMepc:     old_val = mepc_q;
            AddrMcause:   old_val = mcause_q;
            AddrMip:      old_val = mip_rd;
            AddrMtimecmp: old_val = mtimecmp_q;
            AddrMtime:    old_val = mtime_q;
            default:      mapped  = 1'b0;
        endcase
    end

    always_comb begin
        new_val = old_val;
        case (csr_op)
            2'b01:   new_val = csr_wdata;
            2'b10:   new_val = old_val | csr_wdata;
            2'b11:   new_val = old_val & ~csr_wdata;
            default: new_val = old_val;
        endcase
    end

    assign csr_rdata   = old_val;
    assign csr_illegal = (csr_op != 2'b00) && !mapped;
    // Trap and mret both suppress any CSR write issued in the same cycle.
    assign csr_we      = (csr_op != 2'b00) && mapped && !trap_valid && !mret_valid;

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtimecmp_d     = mtimecmp_q;
        mtime_d        = mtime_q;
        presc_d        = presc_q;

        if (trap_valid) begin
            mepc_d         = trap_pc & ~XLEN'(1);
            mcause_d       = trap_cause;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_valid) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                AddrMstatus: begin
                    mstatus_mie_d  = new_val[3];
                    mstatus_mpie_d = new_val[7];
                end
                AddrMie:      mie_d      = new_val;
                AddrMtvec:    mtvec_d    = new_val & ~XLEN'(3);
                AddrMepc:     mepc_d     = new_val & ~XLEN'(1);
                AddrMcause:   mcause_d   = new_val;
                AddrMtimecmp: mtimecmp_d = new_val;
                default:      ;
            endcase
        end

        // A committed mtime write takes precedence over the prescaler tick.
        if (csr_we && (csr_addr == AddrMtime)) begin
            mtime_d = new_val;
            presc_d = '0;
        end else if (presc_q == PresTerm) begin
            mtime_d = mtime_q + 1'b1;
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtimecmp_q     <= '1;
            mtime_q        <= '0;
            presc_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtimecmp_q     <= mtimecmp_d;
            mtime_q        <= mtime_d;
            presc_q        <= presc_d;
        end
    end

    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;
    assign irq_timer = mstatus_mie_q & mie_q[7] & mtip;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: expected post-write values queued at drive time, checked on
// the following read. A second instance with MTIME_DIV=1 covers mtime wrap.
module tb_csr_file;

    localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [63:0] csr_wdata, trap_pc, trap_cause;
    logic        trap_valid, mret_valid;
    logic [63:0] csr_rdata, mtvec_out, mepc_out;
    logic        csr_illegal, irq_timer;
    logic [63:0] rdata1, mtvec1, mepc1;
    logic        illegal1, irq1;

    int checks = 0;
    int failures = 0;

    string       tag_q[$];
    logic [11:0] addr_q[$];
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    csr_file #(.XLEN(64), .MTIME_DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .mret_valid(mret_valid), .mtvec_out(mtvec_out), .mepc_out(mepc_out),
        .irq_timer(irq_timer)
    );

    csr_file #(.XLEN(64), .MTIME_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_rdata(rdata1), .csr_illegal(illegal1),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .mret_valid(mret_valid), .mtvec_out(mtvec1), .mepc_out(mepc1),
        .irq_timer(irq1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's worth of inputs at the falling edge; sample 1 time unit later.
    task automatic cyc(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd,
                       input logic tv, input logic mv);
        @(negedge clk);
        csr_addr   = a;
        csr_op     = op;
        csr_wdata  = wd;
        trap_valid = tv;
        mret_valid = mv;
        #1;
    endtask

    task automatic push(input string tag, input logic [11:0] a, input logic [63:0] e);
        tag_q.push_back(tag);
        addr_q.push_back(a);
        exp_q.push_back(e);
    endtask

    task automatic rd_sb();
        string       t;
        logic [11:0] a;
        logic [63:0] e;
        t = tag_q.pop_front();
        a = addr_q.pop_front();
        e = exp_q.pop_front();
        cyc(a, 2'b00, 64'd0, 1'b0, 1'b0);
        chk(t, csr_rdata, e);
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] e);
        cyc(a, 2'b00, 64'd0, 1'b0, 1'b0);
        chk(tag, csr_rdata, e);
    endtask

    task automatic wr(input string tag, input logic [11:0] a, input logic [1:0] op,
                      input logic [63:0] wd, input logic [63:0] e_old, input logic [63:0] e_new);
        cyc(a, op, wd, 1'b0, 1'b0);
        chk({tag, "_old"}, csr_rdata, e_old);
        chk({tag, "_ill"}, {63'd0, csr_illegal}, 64'd0);
        push(tag, a, e_new);
        rd_sb();
    endtask

    initial begin
        rst_n = 1'b0;
        csr_addr = '0; csr_op = '0; csr_wdata = '0;
        trap_valid = 1'b0; mret_valid = 1'b0; trap_pc = '0; trap_cause = '0;

        rd("rst_mstatus", 12'h300, 64'h1800);
        rd("rst_mie", 12'h304, 64'd0);
        rd("rst_mtvec", 12'h305, 64'd0);
        rd("rst_mepc", 12'h341, 64'd0);
        rd("rst_mcause", 12'h342, 64'd0);
        rd("rst_mip", 12'h344, 64'd0);
        rd("rst_mtimecmp", 12'h7C0, Ones);
        rd("rst_mtime", 12'h7C1, 64'd0);
        chk("rst_irq", {63'd0, irq_timer}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        cyc(12'h123, 2'b01, Ones, 1'b0, 1'b0);
        chk("unmapped_ill", {63'd0, csr_illegal}, 64'd1);
        chk("unmapped_rdata", csr_rdata, 64'd0);
        cyc(12'h123, 2'b00, Ones, 1'b0, 1'b0);
        chk("unmapped_op0_ill", {63'd0, csr_illegal}, 64'd0);
        rd("unmapped_nowrite", 12'h300, 64'h1800);

        wr("mtvec_rw", 12'h305, 2'b01, 64'h8000_0003, 64'd0, 64'h8000_0000);
        wr("mie_rs", 12'h304, 2'b10, 64'h80, 64'd0, 64'h80);
        wr("mie_rc", 12'h304, 2'b11, 64'h80, 64'h80, 64'd0);
        wr("mepc_rw", 12'h341, 2'b01, 64'h1235, 64'd0, 64'h1234);
        wr("mip_ro", 12'h344, 2'b01, Ones, 64'd0, 64'd0);
        wr("mstatus_mask", 12'h300, 2'b01, Ones, 64'h1800, 64'h1888);
        wr("mstatus_mie", 12'h300, 2'b01, 64'h8, 64'h1888, 64'h1808);

        trap_pc = 64'h8000_0105; trap_cause = 64'hB;
        cyc(12'h000, 2'b00, 64'd0, 1'b1, 1'b0);
        push("trap_mepc", 12'h341, 64'h8000_0104);
        push("trap_mcause", 12'h342, 64'hB);
        push("trap_mstatus", 12'h300, 64'h1880);
        rd_sb(); rd_sb(); rd_sb();
        chk("trap_mepc_out", mepc_out, 64'h8000_0104);

        cyc(12'h000, 2'b00, 64'd0, 1'b0, 1'b1);
        push("mret_mstatus", 12'h300, 64'h1888);
        rd_sb();

        trap_pc = 64'h200; trap_cause = 64'h3;
        cyc(12'h305, 2'b01, 64'h40, 1'b1, 1'b1);
        chk("prio_ill", {63'd0, csr_illegal}, 64'd0);
        push("prio_mtvec", 12'h305, 64'h8000_0000);
        push("prio_mepc", 12'h341, 64'h200);
        push("prio_mcause", 12'h342, 64'h3);
        push("prio_mstatus", 12'h300, 64'h1880);
        rd_sb(); rd_sb(); rd_sb(); rd_sb();
        chk("prio_mtvec_out", mtvec_out, 64'h8000_0000);

        cyc(12'h305, 2'b01, 64'h40, 1'b0, 1'b1);
        push("mret_drop_mtvec", 12'h305, 64'h8000_0000);
        push("mret_drop_mstatus", 12'h300, 64'h1888);
        rd_sb(); rd_sb();
        chk("dut1_mtvec_out", mtvec1, 64'h8000_0000);

        // Timer: mtime parked at 100, then enable and arm compare at 3.
        cyc(12'h7C1, 2'b01, 64'd100, 1'b0, 1'b0);
        cyc(12'h304, 2'b01, 64'h80, 1'b0, 1'b0);
        cyc(12'h300, 2'b01, 64'h8, 1'b0, 1'b0);
        cyc(12'h7C0, 2'b01, 64'd3, 1'b0, 1'b0);
        chk("irq_before_cmp", {63'd0, irq_timer}, 64'd0);
        rd("mtime_hold", 12'h7C1, 64'd100);
        chk("irq_on_cmp", {63'd0, irq_timer}, 64'd1);
        cyc(12'h7C1, 2'b01, 64'd0, 1'b0, 1'b0);
        chk("mtime_div4_old", csr_rdata, 64'd101);
        chk("irq_pre_clear", {63'd0, irq_timer}, 64'd1);
        for (int k = 0; k < 14; k++) begin
            rd($sformatf("mtime_k%0d", k), 12'h7C1, 64'(k / 4));
            chk($sformatf("irq_k%0d", k), {63'd0, irq_timer}, (k >= 12) ? 64'd1 : 64'd0);
        end

        cyc(12'h7C1, 2'b01, Ones, 1'b0, 1'b0);
        cyc(12'h7C1, 2'b00, 64'd0, 1'b0, 1'b0);
        chk("wrap_ones", rdata1, Ones);
        chk("wrap_irq_hi", {63'd0, irq1}, 64'd1);
        cyc(12'h7C1, 2'b00, 64'd0, 1'b0, 1'b0);
        chk("wrap_zero", rdata1, 64'd0);
        chk("wrap_irq_lo", {63'd0, irq1}, 64'd0);
        chk("wrap_ill", {63'd0, illegal1}, 64'd0);

        cyc(12'h7C1, 2'b00, 64'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mtime", csr_rdata, 64'd0);
        chk("arst_irq", {63'd0, irq_timer}, 64'd0);
        chk("arst_mepc_out", mepc1, 64'd0);
        rd("arst_mstatus", 12'h300, 64'h1800);
        rd("arst_mtimecmp", 12'h7C0, Ones);
        rd("arst_mtvec", 12'h305, 64'd0);
        rd("arst_mie", 12'h304, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wr("post_rst_mtvec", 12'h305, 2'b01, 64'h100, 64'd0, 64'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
